lm32_tlb_maint_ctrl: RTL and testbench
======================================

Name: lm32_tlb_maint_ctrl

Overview:
Maintenance sequencer for the lm32 TLB data RAM write port (ITLB/DTLB instances alike). Accepts flush-all, update-entry and invalidate-entry operations from two requesters: requester 0 is the CSR front-end and requester 1 is the system/mode-switch logic. Arbitrates between them round-robin and drives the RAM write port one entry per cycle. Blocks TLB lookups while a maintenance write is in progress, and performs an automatic full flush out of reset.

Parameters:
tlb_sets, 1024, number of TLB entries (power of two, >=2)
page_size, 4096, page size in bytes (power of two)
(derived localparams: index_width = CLOG2(tlb_sets); vpfn_width = 32 - CLOG2(page_size); tag_width = vpfn_width - index_width; entry_width = 1 + tag_width + vpfn_width)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset; synchronous, active-high
r0_valid_i  in  1  requester 0 has an operation
r0_op_i  in  2  00 reserved, 01 FLUSH, 10 UPDATE, 11 INVALIDATE
r0_vaddr_i  in  32  virtual address (index/tag source)
r0_paddr_i  in  32  physical address (PFN source, UPDATE only)
r0_ready_o  out  1  requester 0 operation accepted this cycle when valid&ready
r1_valid_i, r1_op_i, r1_vaddr_i, r1_paddr_i, r1_ready_o  same as r0, for requester 1
ram_we_o  out  1  TLB RAM write enable
ram_waddr_o  out  index_width  TLB RAM write index
ram_wdata_o  out  entry_width  {valid, tag, pfn}
lookup_block_o  out  1  high while a maintenance write is in progress; lookups must stall
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when an operation completes
done_id_o  out  1  requester id of completed operation (valid with done_o)
done_err_o  out  1  with done_o: reserved op was issued

Behaviour:
- States: IDLE, WRITE, FLUSH, NOP. Outputs decode combinationally from state and registers.
- Reset: state=FLUSH, flush_cnt=tlb_sets-1, rr_ptr=0 (requester 0 favoured), latched request cleared.
  - Reset-time outputs: ram_we_o=1, ram_waddr_o=tlb_sets-1, ram_wdata_o=0, busy_o=1, lookup_block_o=1, ready=0/0, done_o=0, done_id_o=0, done_err_o=0.
  - The reset sweep pulses done_o on its final write with done_id_o=0 and done_err_o=0.
- IDLE:
  - ready_o goes high only for the granted requester.
  - Grant when only one requester is valid: that requester. When both are valid: the one indicated by rr_ptr.
  - On acceptance: latch op/vaddr/paddr/id, set rr_ptr to !id, go to FLUSH (flush_cnt=tlb_sets-1), WRITE, or NOP by op.
  - Dropping valid without a handshake is legal and causes no effect.
- WRITE: one cycle, then IDLE.
  - Signals: ram_we_o=1, ram_waddr_o=vaddr[idx], done_o=1.
  - UPDATE data: wdata = {1, vaddr[tag], paddr[31:32-vpfn_width]}.
  - INVALIDATE data: wdata = 0.
  - Accept-to-write latency is 1 cycle.
- FLUSH: ram_we_o=1, waddr=flush_cnt, wdata=0, flush_cnt decrements each cycle.
  - When flush_cnt==0 is written: done_o=1, next state IDLE.
  - No wrap-around; exactly tlb_sets writes occur, from tlb_sets-1 down to 0.
- NOP: one cycle, no write, done_o=1, done_err_o=1, then IDLE.
- lookup_block_o = busy_o. It is also high during NOP, to keep the logic simple.
- No operation is accepted while busy; ready_o=0 in every non-IDLE state.
- Back-to-back operations: the earliest next acceptance is the cycle after completion (IDLE cycle).
- Reset asserted mid-operation: the in-flight op is abandoned with no done_o, and the full reset sweep restarts.
- Field ranges:
  - idx = [CLOG2(page_size)+index_width-1 : CLOG2(page_size)]
  - tag = [31 : CLOG2(page_size)+index_width]

Decomposition:
- Shared include: op encodings (LM32_TLB_OP_FLUSH/UPDATE/INVALIDATE/RSVD) and state encodings, defined alongside the existing TLB control defines, plus the field-range macros, so that the ITLB and DTLB use identical definitions.
- One natural sub-module: lm32_rr_arb2, a two-input round-robin arbiter (valid in, grant out, pointer update on accept).

Test Plan:
- Reset sweep → ram_we_o high for exactly 1024 cycles; waddr runs 1023..0; wdata=0 throughout; single done_o on waddr=0; then busy_o=0.
- r0 UPDATE, vaddr=0x00403000, paddr=0x80005000 → next cycle ram_we_o=1, waddr=0x003, wdata={1,tag=0x001,pfn=0x80005}, done_o=1, done_id_o=0.
- r1 INVALIDATE, vaddr=0x00403000 → waddr=0x003, wdata=0, done_id_o=1, lookup_block_o high for 1 cycle.
- Both valid in IDLE right after reset, both holding UPDATE → r0 granted first; r1 granted at the next IDLE; with both continuously valid, grants alternate 0,1,0,1.
- r0 op=00 → no ram_we_o; done_o=1 with done_err_o=1 one cycle after acceptance.
- FLUSH accepted, rst_i asserted at sweep index 500 → no done_o for that op; sweep restarts at 1023 and completes in 1024 cycles.

Source files
------------

// File: rtl/lm32_tlb_maint_ctrl_pkg.sv
// Shared TLB maintenance definitions: operation codes, sequencer states and
// geometry helpers used identically by the ITLB and DTLB instances.
package lm32_tlb_maint_ctrl_pkg;

   typedef enum logic [1:0] {
      LM32_TLB_OP_RSVD       = 2'b00,
      LM32_TLB_OP_FLUSH      = 2'b01,
      LM32_TLB_OP_UPDATE     = 2'b10,
      LM32_TLB_OP_INVALIDATE = 2'b11
   } tlb_op_e;

   typedef enum logic [1:0] {
      LM32_TLB_ST_IDLE  = 2'b00,
      LM32_TLB_ST_WRITE = 2'b01,
      LM32_TLB_ST_FLUSH = 2'b10,
      LM32_TLB_ST_NOP   = 2'b11
   } tlb_state_e;

   // Entry layout is {valid, tag, pfn}; the tag covers what the index does not.
   function automatic int tlb_entry_width(input int sets, input int page);
      return 1 + (32 - $clog2(page) - $clog2(sets)) + (32 - $clog2(page));
   endfunction

endpackage

// File: rtl/lm32_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on
// the next contended grant and flips to the other side after each acceptance.
module lm32_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       accept_i,
   output logic [1:0] grant_o,
   output logic       grant_id_o
);

   logic rr_ptr_q;
   logic rr_ptr_d;

   always_comb begin
      grant_id_o = rr_ptr_q;
      if (valid_i == 2'b01) begin
         grant_id_o = 1'b0;
      end else if (valid_i == 2'b10) begin
         grant_id_o = 1'b1;
      end

      grant_o = 2'b00;
      if (valid_i != 2'b00) begin
         grant_o = grant_id_o ? 2'b10 : 2'b01;
      end

      rr_ptr_d = rr_ptr_q;
      if (accept_i) begin
         rr_ptr_d = ~grant_id_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/lm32_tlb_maint_ctrl.sv
// TLB data RAM maintenance sequencer: arbitrates flush/update/invalidate
// requests from two sources and drives the RAM write port one entry per cycle.
module lm32_tlb_maint_ctrl
   import lm32_tlb_maint_ctrl_pkg::*;
#(
   parameter int tlb_sets  = 1024,
   parameter int page_size = 4096,
   localparam int index_width = $clog2(tlb_sets),
   localparam int offset_width = $clog2(page_size),
   localparam int vpfn_width  = 32 - offset_width,
   localparam int tag_width   = vpfn_width - index_width,
   localparam int entry_width = tlb_entry_width(tlb_sets, page_size)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   r0_valid_i,
   input  logic [1:0]             r0_op_i,
   input  logic [31:0]            r0_vaddr_i,
   input  logic [31:0]            r0_paddr_i,
   output logic                   r0_ready_o,
   input  logic                   r1_valid_i,
   input  logic [1:0]             r1_op_i,
   input  logic [31:0]            r1_vaddr_i,
   input  logic [31:0]            r1_paddr_i,
   output logic                   r1_ready_o,
   output logic                   ram_we_o,
   output logic [index_width-1:0] ram_waddr_o,
   output logic [entry_width-1:0] ram_wdata_o,
   output logic                   lookup_block_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   done_id_o,
   output logic                   done_err_o
);

   localparam logic [index_width-1:0] last_index = index_width'(tlb_sets - 1);

   tlb_state_e             state_q, state_d;
   logic [index_width-1:0] flush_cnt_q, flush_cnt_d;
   tlb_op_e                op_q, op_d;
   logic [index_width-1:0] idx_q, idx_d;
   logic [tag_width-1:0]   tag_q, tag_d;
   logic [vpfn_width-1:0]  pfn_q, pfn_d;
   logic                   id_q, id_d;

   logic [1:0]  grant;
   logic        grant_id;
   logic        accept;
   logic [1:0]  sel_op;
   logic [31:0] sel_vaddr;
   logic [31:0] sel_paddr;
   logic        unused_offset_bits;

   assign accept = (state_q == LM32_TLB_ST_IDLE) && (r0_valid_i || r1_valid_i);

   lm32_rr_arb2 u_arb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    ({r1_valid_i, r0_valid_i}),
      .accept_i   (accept),
      .grant_o    (grant),
      .grant_id_o (grant_id)
   );

   assign sel_op    = grant_id ? r1_op_i    : r0_op_i;
   assign sel_vaddr = grant_id ? r1_vaddr_i : r0_vaddr_i;
   assign sel_paddr = grant_id ? r1_paddr_i : r0_paddr_i;

   // Page-offset bits never reach the RAM entry.
   assign unused_offset_bits = ^{sel_vaddr[offset_width-1:0], sel_paddr[offset_width-1:0]};

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      op_d        = op_q;
      idx_d       = idx_q;
      tag_d       = tag_q;
      pfn_d       = pfn_q;
      id_d        = id_q;

      r0_ready_o  = 1'b0;
      r1_ready_o  = 1'b0;
      ram_we_o    = 1'b0;
      ram_waddr_o = '0;
      ram_wdata_o = '0;
      done_o      = 1'b0;
      done_id_o   = id_q;
      done_err_o  = 1'b0;

      unique case (state_q)
         LM32_TLB_ST_IDLE: begin
            done_id_o  = 1'b0;
            r0_ready_o = grant[0];
            r1_ready_o = grant[1];
            if (accept) begin
               op_d  = tlb_op_e'(sel_op);
               idx_d = sel_vaddr[offset_width +: index_width];
               tag_d = sel_vaddr[31 -: tag_width];
               pfn_d = sel_paddr[31 -: vpfn_width];
               id_d  = grant_id;
               unique case (tlb_op_e'(sel_op))
                  LM32_TLB_OP_FLUSH: begin
                     state_d     = LM32_TLB_ST_FLUSH;
                     flush_cnt_d = last_index;
                  end
                  LM32_TLB_OP_UPDATE,
                  LM32_TLB_OP_INVALIDATE: state_d = LM32_TLB_ST_WRITE;
                  default:                state_d = LM32_TLB_ST_NOP;
               endcase
            end
         end
         LM32_TLB_ST_WRITE: begin
            ram_we_o    = 1'b1;
            ram_waddr_o = idx_q;
            if (op_q == LM32_TLB_OP_UPDATE) begin
               ram_wdata_o = {1'b1, tag_q, pfn_q};
            end
            done_o  = 1'b1;
            state_d = LM32_TLB_ST_IDLE;
         end
         LM32_TLB_ST_FLUSH: begin
            ram_we_o    = 1'b1;
            ram_waddr_o = flush_cnt_q;
            if (flush_cnt_q == '0) begin
               done_o  = 1'b1;
               state_d = LM32_TLB_ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end
         default: begin
            done_o     = 1'b1;
            done_err_o = 1'b1;
            state_d    = LM32_TLB_ST_IDLE;
         end
      endcase
   end

   assign busy_o         = (state_q != LM32_TLB_ST_IDLE);
   assign lookup_block_o = busy_o;

   // Reset lands directly in a full sweep so the RAM never holds stale entries.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= LM32_TLB_ST_FLUSH;
         flush_cnt_q <= last_index;
         op_q        <= LM32_TLB_OP_RSVD;
         idx_q       <= '0;
         tag_q       <= '0;
         pfn_q       <= '0;
         id_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         tag_q       <= tag_d;
         pfn_q       <= pfn_d;
         id_q        <= id_d;
      end
   end

endmodule

// File: tb/tb_lm32_tlb_maint_ctrl.sv
// Directed self-checking bench for lm32_tlb_maint_ctrl with default geometry
// (1024 entries, 4 KiB pages, 31-bit entries).
module tb_lm32_tlb_maint_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        r0_valid_i = 1'b0;
   logic [1:0]  r0_op_i = 2'b00;
   logic [31:0] r0_vaddr_i = '0;
   logic [31:0] r0_paddr_i = '0;
   logic        r0_ready_o;
   logic        r1_valid_i = 1'b0;
   logic [1:0]  r1_op_i = 2'b00;
   logic [31:0] r1_vaddr_i = '0;
   logic [31:0] r1_paddr_i = '0;
   logic        r1_ready_o;
   logic        ram_we_o;
   logic [9:0]  ram_waddr_o;
   logic [30:0] ram_wdata_o;
   logic        lookup_block_o;
   logic        busy_o;
   logic        done_o;
   logic        done_id_o;
   logic        done_err_o;

   int checks = 0;
   int errors = 0;

   lm32_tlb_maint_ctrl #(.tlb_sets(1024), .page_size(4096)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .r0_valid_i     (r0_valid_i),
      .r0_op_i        (r0_op_i),
      .r0_vaddr_i     (r0_vaddr_i),
      .r0_paddr_i     (r0_paddr_i),
      .r0_ready_o     (r0_ready_o),
      .r1_valid_i     (r1_valid_i),
      .r1_op_i        (r1_op_i),
      .r1_vaddr_i     (r1_vaddr_i),
      .r1_paddr_i     (r1_paddr_i),
      .r1_ready_o     (r1_ready_o),
      .ram_we_o       (ram_we_o),
      .ram_waddr_o    (ram_waddr_o),
      .ram_wdata_o    (ram_wdata_o),
      .lookup_block_o (lookup_block_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .done_id_o      (done_id_o),
      .done_err_o     (done_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Observes 1024 sweep cycles starting at the current negedge; leaves the
   // bench at the first negedge after the sweep.
   task automatic check_sweep(input string name);
      int bad_we = 0, bad_addr = 0, bad_data = 0, done_cnt = 0, done_pos = -1, bad_id = 0;
      for (int i = 0; i < 1024; i++) begin
         if (ram_we_o !== 1'b1) bad_we++;
         if (ram_waddr_o !== 10'(1023 - i)) bad_addr++;
         if (ram_wdata_o !== 31'h0) bad_data++;
         if (done_o === 1'b1) begin
            done_cnt++;
            done_pos = i;
            if (done_id_o !== 1'b0 || done_err_o !== 1'b0) bad_id++;
         end
         @(negedge clk_i);
      end
      checks++;
      if (bad_we != 0 || bad_addr != 0 || bad_data != 0) begin
         errors++;
         $display("FAIL %s_writes: bad_we=%0d bad_addr=%0d bad_data=%0d, required all 0", name, bad_we, bad_addr, bad_data);
      end
      checks++;
      if (done_cnt != 1 || done_pos != 1023 || bad_id != 0) begin
         errors++;
         $display("FAIL %s_done: count=%0d pos=%0d bad_id=%0d, required count=1 pos=1023 bad_id=0", name, done_cnt, done_pos, bad_id);
      end
      checks++;
      if (busy_o !== 1'b0 || ram_we_o !== 1'b0 || lookup_block_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b we=%b block=%b, required 0 0 0", name, busy_o, ram_we_o, lookup_block_o);
      end
      $display("txn %s: sweep observed, done at pos %0d", name, done_pos);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({ram_we_o, ram_waddr_o, ram_wdata_o, busy_o, lookup_block_o, r0_ready_o, r1_ready_o, done_o, done_id_o, done_err_o}
          !== {1'b1, 10'd1023, 31'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%h busy=%b blk=%b rdy=%b%b done=%b id=%b err=%b, required 1 1023 0 1 1 00 0 0 0",
                  ram_we_o, ram_waddr_o, ram_wdata_o, busy_o, lookup_block_o, r0_ready_o, r1_ready_o, done_o, done_id_o, done_err_o);
      end
      rst_i = 1'b0;
      check_sweep("reset_sweep");
   endtask

   task automatic test_update();
      r0_valid_i = 1'b1; r0_op_i = 2'b10; r0_vaddr_i = 32'h0040_3000; r0_paddr_i = 32'h8000_5000;
      #1;
      checks++;
      if (r0_ready_o !== 1'b1 || r1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL update_ready: r0=%b r1=%b, required 1 0", r0_ready_o, r1_ready_o);
      end
      @(negedge clk_i);
      r0_valid_i = 1'b0;
      checks++;
      if ({ram_we_o, ram_waddr_o, ram_wdata_o, done_o, done_id_o, done_err_o, r0_ready_o}
          !== {1'b1, 10'h003, 31'h4018_0005, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL update_write: we=%b waddr=%h wdata=%h done=%b id=%b err=%b rdy=%b, required 1 003 40180005 1 0 0 0",
                  ram_we_o, ram_waddr_o, ram_wdata_o, done_o, done_id_o, done_err_o, r0_ready_o);
      end
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || ram_we_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL update_after: busy=%b we=%b done=%b, required 0 0 0", busy_o, ram_we_o, done_o);
      end
      $display("txn update r0: waddr=003 wdata=40180005");
   endtask

   task automatic test_invalidate();
      r1_valid_i = 1'b1; r1_op_i = 2'b11; r1_vaddr_i = 32'h0040_3000; r1_paddr_i = 32'hFFFF_F000;
      #1;
      checks++;
      if (r1_ready_o !== 1'b1 || r0_ready_o !== 1'b0 || lookup_block_o !== 1'b0) begin
         errors++;
         $display("FAIL inval_ready: r1=%b r0=%b blk=%b, required 1 0 0", r1_ready_o, r0_ready_o, lookup_block_o);
      end
      @(negedge clk_i);
      r1_valid_i = 1'b0;
      checks++;
      if ({ram_we_o, ram_waddr_o, ram_wdata_o, done_o, done_id_o, lookup_block_o}
          !== {1'b1, 10'h003, 31'h0, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL inval_write: we=%b waddr=%h wdata=%h done=%b id=%b blk=%b, required 1 003 0 1 1 1",
                  ram_we_o, ram_waddr_o, ram_wdata_o, done_o, done_id_o, lookup_block_o);
      end
      @(negedge clk_i);
      checks++;
      if (lookup_block_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL inval_after: blk=%b done=%b, required 0 0", lookup_block_o, done_o);
      end
      $display("txn invalidate r1: waddr=003 wdata=0");
   endtask

   task automatic test_back_to_back();
      logic [9:0]  exp_addr [2];
      logic [30:0] exp_data [2];
      exp_addr[0] = 10'h001; exp_data[0] = 31'h4001_1111;
      exp_addr[1] = 10'h002; exp_data[1] = 31'h4022_2222;
      r0_valid_i = 1'b1; r0_op_i = 2'b10; r0_vaddr_i = 32'h0000_1000; r0_paddr_i = 32'h1111_1000;
      r1_valid_i = 1'b1; r1_op_i = 2'b10; r1_vaddr_i = 32'h0080_2000; r1_paddr_i = 32'h2222_2000;
      #1;
      for (int g = 0; g < 4; g++) begin
         int id = g % 2;
         checks++;
         if (r0_ready_o !== (id == 0) || r1_ready_o !== (id == 1)) begin
            errors++;
            $display("FAIL b2b_grant%0d: rdy r0=%b r1=%b, required r%0d only", g, r0_ready_o, r1_ready_o, id);
         end
         @(negedge clk_i);
         checks++;
         if ({ram_we_o, ram_waddr_o, ram_wdata_o, done_o, done_id_o, r0_ready_o, r1_ready_o}
             !== {1'b1, exp_addr[id], exp_data[id], 1'b1, 1'(id), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_write%0d: we=%b waddr=%h wdata=%h done=%b id=%b rdy=%b%b, required 1 %h %h 1 %0d 00",
                     g, ram_we_o, ram_waddr_o, ram_wdata_o, done_o, done_id_o, r0_ready_o, r1_ready_o, exp_addr[id], exp_data[id], id);
         end
         $display("txn b2b grant %0d -> r%0d waddr=%h", g, done_id_o, ram_waddr_o);
         @(negedge clk_i);
      end
      r0_valid_i = 1'b0; r1_valid_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || r0_ready_o !== 1'b0 || r1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drop: busy=%b rdy=%b%b, required 0 00", busy_o, r0_ready_o, r1_ready_o);
      end
      @(negedge clk_i);
   endtask

   task automatic test_reserved();
      r0_valid_i = 1'b1; r0_op_i = 2'b00; r0_vaddr_i = 32'h0000_5000; r0_paddr_i = '0;
      #1;
      checks++;
      if (r0_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rsvd_ready: r0=%b, required 1", r0_ready_o);
      end
      @(negedge clk_i);
      r0_valid_i = 1'b0;
      checks++;
      if ({ram_we_o, done_o, done_err_o, done_id_o, busy_o, lookup_block_o} !== 6'b011011) begin
         errors++;
         $display("FAIL rsvd_nop: we=%b done=%b err=%b id=%b busy=%b blk=%b, required 0 1 1 0 1 1",
                  ram_we_o, done_o, done_err_o, done_id_o, busy_o, lookup_block_o);
      end
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || done_err_o !== 1'b0) begin
         errors++;
         $display("FAIL rsvd_after: busy=%b done=%b err=%b, required 0 0 0", busy_o, done_o, done_err_o);
      end
      $display("txn reserved r0: nop with error");
   endtask

   task automatic test_flush_reset();
      int early_done = 0;
      r1_valid_i = 1'b1; r1_op_i = 2'b01; r1_vaddr_i = '0; r1_paddr_i = '0;
      #1;
      checks++;
      if (r1_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: r1=%b, required 1", r1_ready_o);
      end
      @(negedge clk_i);
      r1_valid_i = 1'b0;
      for (int i = 0; i < 523; i++) begin
         if (done_o === 1'b1) early_done++;
         @(negedge clk_i);
      end
      checks++;
      if (ram_waddr_o !== 10'd500 || ram_we_o !== 1'b1 || early_done != 0) begin
         errors++;
         $display("FAIL flush_mid: waddr=%0d we=%b early_done=%0d, required 500 1 0", ram_waddr_o, ram_we_o, early_done);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (ram_waddr_o !== 10'd1023 || done_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_restart: waddr=%0d done=%b busy=%b, required 1023 0 1", ram_waddr_o, done_o, busy_o);
      end
      rst_i = 1'b0;
      check_sweep("flush_reset_sweep");
   endtask

   initial begin
      @(negedge clk_i);
      test_reset();
      test_update();
      test_invalidate();
      test_back_to_back();
      test_reserved();
      test_flush_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
